// File: rtl/audio_minmax_win_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : audio_minmax_win_ctrl_if                                     |
// | Purpose  : Sample-RAM read port and window-result valid/ready port of  |
// |            the windowed min/max sequencer.                              |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
interface audio_minmax_win_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 7
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_max;
   logic [DATA_W-1:0] res_min;
   logic [ADDR_W:0]   res_idx;

   // Sequencer side: drives reads and results
   modport master (
      output mem_rd_en, mem_addr, res_valid, res_max, res_min, res_idx,
      input  mem_rd_data, res_ready
   );

   // Environment side: RAM plus result consumer
   modport slave (
      input  mem_rd_en, mem_addr, res_valid, res_max, res_min, res_idx,
      output mem_rd_data, res_ready
   );
endinterface
`default_nettype wire

// File: rtl/audio_minmax_win_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : audio_minmax_win_ctrl                                        |
// | Purpose  : Walks a sample RAM, splits the run into windows and reports |
// |            the signed max/min of every window over valid/ready.        |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module audio_minmax_win_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 7
) (
   input  wire logic              clk,
   input  wire logic              reset,
   input  wire logic              start_i,
   input  wire logic [ADDR_W-1:0] cfg_base_i,
   input  wire logic [ADDR_W:0]   cfg_len_i,
   input  wire logic [ADDR_W:0]   cfg_win_i,
   output      logic              busy_o,
   output      logic              d_o,
   output      logic              err_o,
   audio_minmax_win_ctrl_if.master bus
);

   localparam int CNT_W = ADDR_W + 1;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_LAST  = 3'd2;
   localparam logic [2:0] ST_EMIT  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   logic [2:0]              state_q, state_d;
   logic [ADDR_W-1:0]       base_q;
   logic [CNT_W-1:0]        len_q, win_q;
   logic [CNT_W-1:0]        k_q;       // samples issued since run start
   logic [CNT_W-1:0]        wcnt_q;    // samples issued in current window
   logic [CNT_W-1:0]        idx_q;
   logic                    rd_q;      // a read was issued last cycle
   logic                    first_q;   // next returned sample opens a window
   logic                    err_q;
   logic signed [DATA_W-1:0] max_q, min_q;

   logic                    cfg_bad;
   logic [CNT_W-1:0]        k_inc, wcnt_inc;
   logic                    win_end;
   logic                    run_done;
   logic                    accept;
   logic signed [DATA_W-1:0] sample;

   assign cfg_bad  = (cfg_len_i == '0) || (cfg_win_i == '0) || (cfg_win_i > cfg_len_i);
   assign k_inc    = k_q + 1'b1;
   assign wcnt_inc = wcnt_q + 1'b1;
   // The address being issued now is the last of the window (full or short tail)
   assign win_end  = (wcnt_inc == win_q) || (k_inc == len_q);
   assign run_done = (k_q == len_q);
   assign accept   = (state_q == ST_IDLE) && start_i;
   assign sample   = bus.mem_rd_data;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_i) state_d = cfg_bad ? ST_DONE : ST_FETCH;
         ST_FETCH: if (win_end) state_d = ST_LAST;
         ST_LAST:  state_d = ST_EMIT;
         ST_EMIT:  if (bus.res_ready) state_d = run_done ? ST_DONE : ST_FETCH;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      bus.mem_rd_en = (state_q == ST_FETCH);
      bus.mem_addr  = (state_q == ST_FETCH) ? (base_q + k_q[ADDR_W-1:0]) : '0;
      bus.res_valid = (state_q == ST_EMIT);
      bus.res_max   = max_q;
      bus.res_min   = min_q;
      bus.res_idx   = idx_q;
      busy_o        = (state_q != ST_IDLE);
      d_o           = (state_q == ST_DONE);
      err_o         = (state_q == ST_DONE) && err_q;
   end

   // Config latch, sample counters and running signed max/min
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q  <= '0;
         len_q   <= '0;
         win_q   <= '0;
         k_q     <= '0;
         wcnt_q  <= '0;
         idx_q   <= '0;
         rd_q    <= 1'b0;
         first_q <= 1'b0;
         err_q   <= 1'b0;
         max_q   <= '0;
         min_q   <= '0;
      end else begin
         rd_q <= (state_q == ST_FETCH);
         if (accept) begin
            base_q  <= cfg_base_i;
            len_q   <= cfg_len_i;
            win_q   <= cfg_win_i;
            err_q   <= cfg_bad;
            k_q     <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            first_q <= 1'b1;
         end
         if (state_q == ST_FETCH) begin
            k_q    <= k_inc;
            wcnt_q <= wcnt_inc;
         end
         // RAM data lands one cycle after its read strobe
         if (rd_q) begin
            if (first_q) begin
               max_q   <= sample;
               min_q   <= sample;
               first_q <= 1'b0;
            end else begin
               if (sample > max_q) max_q <= sample;
               if (sample < min_q) min_q <= sample;
            end
         end
         if ((state_q == ST_EMIT) && bus.res_ready && !run_done) begin
            idx_q   <= idx_q + 1'b1;
            wcnt_q  <= '0;
            first_q <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_audio_minmax_win_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_audio_minmax_win_ctrl                                     |
// | Purpose  : Directed and randomized runs of the windowed min/max        |
// |            sequencer checked against a per-window reference model.     |
// | Revision : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_audio_minmax_win_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W:0]   cfg_len, cfg_win;
    logic              busy, d, err;

    int checks   = 0;
    int failures = 0;

    logic signed [DATA_W-1:0] mem [0:DEPTH-1];
    int addr_log [$];

    audio_minmax_win_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    audio_minmax_win_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start),
        .cfg_base_i (cfg_base),
        .cfg_len_i  (cfg_len),
        .cfg_win_i  (cfg_win),
        .busy_o     (busy),
        .d_o        (d),
        .err_o      (err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read sample RAM
    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

    // Record every issued read address
    always @(negedge clk) if (bus.mem_rd_en) addr_log.push_back(int'(bus.mem_addr));

    function automatic logic signed [DATA_W-1:0] rand_sample();
        case ($urandom_range(0, 7))
            0:       return 32'sh8000_0000;
            1:       return 32'sh7fff_ffff;
            default: return $signed($urandom());
        endcase
    endfunction

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_sample();
    endtask

    // One complete run: drive start, check each window, the done pulse and addresses
    task automatic run(input int base, input int len, input int win, input bit stall);
        bit  bad;
        int  exp_cnt, cyc, res_n, last_hs, n, a0, exp_reads;
        bit  seen_d;
        logic signed [DATA_W-1:0] emax, emin, hmax, hmin;
        bad       = (len == 0) || (win == 0) || (win > len);
        exp_cnt   = bad ? 0 : (len + win - 1) / win;
        exp_reads = bad ? 0 : len;
        addr_log.delete();
        @(negedge clk);
        cfg_base = ADDR_W'(base);
        cfg_len  = (ADDR_W+1)'(len);
        cfg_win  = (ADDR_W+1)'(win);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cfg_base = ADDR_W'($urandom());
        cfg_len  = (ADDR_W+1)'($urandom());
        cfg_win  = (ADDR_W+1)'($urandom());
        cyc = 1; res_n = 0; last_hs = -10; seen_d = 1'b0;
        while (!seen_d && cyc < 3000) begin
            if (bus.res_valid) begin
                if (res_n < exp_cnt) begin
                    n = len - res_n * win;
                    if (n > win) n = win;
                    a0 = base + res_n * win;
                    emax = mem[a0 % DEPTH];
                    emin = emax;
                    for (int i = 1; i < n; i++) begin
                        if (mem[(a0 + i) % DEPTH] > emax) emax = mem[(a0 + i) % DEPTH];
                        if (mem[(a0 + i) % DEPTH] < emin) emin = mem[(a0 + i) % DEPTH];
                    end
                    if (res_n == 0) begin
                        checks++;
                        if (cyc !== win + 2) begin
                            failures++;
                            $error("FAIL first_valid_cycle: observed=%0d expected=%0d", cyc, win + 2);
                        end
                    end
                    checks++;
                    if ($signed(bus.res_max) !== emax) begin
                        failures++;
                        $error("FAIL res_max: observed=%0d expected=%0d", $signed(bus.res_max), emax);
                    end
                    checks++;
                    if ($signed(bus.res_min) !== emin) begin
                        failures++;
                        $error("FAIL res_min: observed=%0d expected=%0d", $signed(bus.res_min), emin);
                    end
                    checks++;
                    if (int'(bus.res_idx) !== res_n) begin
                        failures++;
                        $error("FAIL res_idx: observed=%0d expected=%0d", int'(bus.res_idx), res_n);
                    end
                end else begin
                    checks++;
                    if (res_n !== exp_cnt) begin
                        failures++;
                        $error("FAIL extra_result: observed=%0d expected=%0d", res_n, exp_cnt);
                    end
                end
                if (stall && res_n == 0) begin
                    hmax = bus.res_max;
                    hmin = bus.res_min;
                    bus.res_ready = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        cyc++;
                        checks++;
                        if (bus.res_valid !== 1'b1) begin
                            failures++;
                            $error("FAIL stall_valid: observed=%0d expected=1", bus.res_valid);
                        end
                        checks++;
                        if ($signed(bus.res_max) !== hmax) begin
                            failures++;
                            $error("FAIL stall_max: observed=%0d expected=%0d", $signed(bus.res_max), hmax);
                        end
                        checks++;
                        if ($signed(bus.res_min) !== hmin) begin
                            failures++;
                            $error("FAIL stall_min: observed=%0d expected=%0d", $signed(bus.res_min), hmin);
                        end
                        checks++;
                        if (int'(bus.res_idx) !== 0) begin
                            failures++;
                            $error("FAIL stall_idx: observed=%0d expected=0", int'(bus.res_idx));
                        end
                        checks++;
                        if (bus.mem_rd_en !== 1'b0) begin
                            failures++;
                            $error("FAIL stall_rd_en: observed=%0d expected=0", bus.mem_rd_en);
                        end
                    end
                    bus.res_ready = 1'b1;
                end
                res_n++;
                last_hs = cyc;
            end
            if (d) begin
                seen_d = 1'b1;
                checks++;
                if (err !== bad) begin
                    failures++;
                    $error("FAIL err_with_d: observed=%0d expected=%0d", err, bad);
                end
                checks++;
                if (res_n !== exp_cnt) begin
                    failures++;
                    $error("FAIL result_count: observed=%0d expected=%0d", res_n, exp_cnt);
                end
                if (bad) begin
                    checks++;
                    if (cyc !== 1) begin
                        failures++;
                        $error("FAIL err_done_cycle: observed=%0d expected=1", cyc);
                    end
                end else begin
                    checks++;
                    if (cyc !== last_hs + 1) begin
                        failures++;
                        $error("FAIL d_after_handshake: observed=%0d expected=%0d", cyc, last_hs + 1);
                    end
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        checks++;
        if (seen_d !== 1'b1) begin
            failures++;
            $error("FAIL d_seen: observed=%0d expected=1", seen_d);
        end
        @(negedge clk);
        checks++;
        if (d !== 1'b0) begin
            failures++;
            $error("FAIL d_one_cycle: observed=%0d expected=0", d);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $error("FAIL err_one_cycle: observed=%0d expected=0", err);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $error("FAIL idle_after_done: observed=%0d expected=0", busy);
        end
        checks++;
        if (addr_log.size() !== exp_reads) begin
            failures++;
            $error("FAIL read_count: observed=%0d expected=%0d", addr_log.size(), exp_reads);
        end
        for (int i = 0; i < addr_log.size() && i < len; i++) begin
            checks++;
            if (addr_log[i] !== (base + i) % DEPTH) begin
                failures++;
                $error("FAIL read_addr: observed=%0d expected=%0d", addr_log[i], (base + i) % DEPTH);
            end
        end
    endtask

    initial begin
        int base, len, win;
        reset         = 1'b1;
        start         = 1'b0;
        cfg_base      = '0;
        cfg_len       = '0;
        cfg_win       = '0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $error("FAIL rst_busy: observed=%0d expected=0", busy);
        end
        checks++;
        if (d !== 1'b0) begin
            failures++;
            $error("FAIL rst_d: observed=%0d expected=0", d);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $error("FAIL rst_err: observed=%0d expected=0", err);
        end
        checks++;
        if (bus.mem_rd_en !== 1'b0) begin
            failures++;
            $error("FAIL rst_rd_en: observed=%0d expected=0", bus.mem_rd_en);
        end
        checks++;
        if (bus.res_valid !== 1'b0) begin
            failures++;
            $error("FAIL rst_valid: observed=%0d expected=0", bus.res_valid);
        end
        checks++;
        if (bus.res_max !== 32'd0) begin
            failures++;
            $error("FAIL rst_max: observed=%0d expected=0", bus.res_max);
        end
        checks++;
        if (bus.res_idx !== 8'd0) begin
            failures++;
            $error("FAIL rst_idx: observed=%0d expected=0", bus.res_idx);
        end
        reset = 1'b0;

        // Capture vector: first half in [-13,7]*2^16, second half in [-27,-9]*2^16
        fill_random();
        for (int i = 0; i < 50; i++)   mem[i] = ($urandom_range(0, 20) - 13) * 65536;
        for (int i = 50; i < 100; i++) mem[i] = ($urandom_range(0, 18) - 27) * 65536;
        mem[7]  = 458752;
        mem[31] = -851968;
        mem[60] = -589824;
        mem[88] = -1769472;
        run(0, 100, 100, 1'b0);
        checks++;
        if ($signed(bus.res_max) !== 458752) begin
            failures++;
            $error("FAIL t1_max: observed=%0d expected=458752", $signed(bus.res_max));
        end
        checks++;
        if ($signed(bus.res_min) !== -1769472) begin
            failures++;
            $error("FAIL t1_min: observed=%0d expected=-1769472", $signed(bus.res_min));
        end
        checks++;
        if (int'(bus.res_idx) !== 0) begin
            failures++;
            $error("FAIL t1_idx: observed=%0d expected=0", int'(bus.res_idx));
        end
        run(0, 100, 50, 1'b0);
        checks++;
        if ($signed(bus.res_max) !== -589824) begin
            failures++;
            $error("FAIL t2_last_max: observed=%0d expected=-589824", $signed(bus.res_max));
        end
        checks++;
        if ($signed(bus.res_min) !== -1769472) begin
            failures++;
            $error("FAIL t2_last_min: observed=%0d expected=-1769472", $signed(bus.res_min));
        end
        checks++;
        if (int'(bus.res_idx) !== 1) begin
            failures++;
            $error("FAIL t2_last_idx: observed=%0d expected=1", int'(bus.res_idx));
        end

        // Short final window, then the same with a stalled consumer
        fill_random();
        run(int'($urandom_range(0, DEPTH-1)), 10, 4, 1'b0);
        run(int'($urandom_range(0, DEPTH-1)), 10, 4, 1'b1);

        // Invalid configurations
        run(3, 5, 0, 1'b0);
        run(3, 5, 8, 1'b0);
        run(3, 0, 1, 1'b0);

        // Single-sample windows and a full-depth wrapping run
        run(126, 5, 1, 1'b0);
        run(64, 128, 128, 1'b0);

        // Randomized runs with full-scale samples mixed in
        for (int r = 0; r < 6; r++) begin
            fill_random();
            base = int'($urandom_range(0, DEPTH-1));
            len  = int'($urandom_range(1, 40));
            win  = int'($urandom_range(1, len));
            run(base, len, win, 1'(r % 2));
        end

        // Reset in the middle of FETCH, then restart with a wrapping base
        @(negedge clk);
        cfg_base = 7'd125;
        cfg_len  = 8'd6;
        cfg_win  = 8'd6;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_rd_en !== 1'b1) begin
            failures++;
            $error("FAIL pre_reset_fetch: observed=%0d expected=1", bus.mem_rd_en);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $error("FAIL mid_rst_busy: observed=%0d expected=0", busy);
        end
        checks++;
        if (bus.mem_rd_en !== 1'b0) begin
            failures++;
            $error("FAIL mid_rst_rd_en: observed=%0d expected=0", bus.mem_rd_en);
        end
        checks++;
        if (bus.mem_addr !== 7'd0) begin
            failures++;
            $error("FAIL mid_rst_addr: observed=%0d expected=0", bus.mem_addr);
        end
        checks++;
        if (bus.res_valid !== 1'b0) begin
            failures++;
            $error("FAIL mid_rst_valid: observed=%0d expected=0", bus.res_valid);
        end
        checks++;
        if (bus.res_max !== 32'd0) begin
            failures++;
            $error("FAIL mid_rst_max: observed=%0d expected=0", bus.res_max);
        end
        checks++;
        if (bus.res_min !== 32'd0) begin
            failures++;
            $error("FAIL mid_rst_min: observed=%0d expected=0", bus.res_min);
        end
        checks++;
        if (bus.res_idx !== 8'd0) begin
            failures++;
            $error("FAIL mid_rst_idx: observed=%0d expected=0", bus.res_idx);
        end
        checks++;
        if (d !== 1'b0) begin
            failures++;
            $error("FAIL mid_rst_d: observed=%0d expected=0", d);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $error("FAIL mid_rst_err: observed=%0d expected=0", err);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $error("FAIL post_rst_idle: observed=%0d expected=0", busy);
        end
        run(125, 6, 6, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
